// File: rtl/cpuclk_ctrl.sv
// cpuclk_ctrl: run/halt/single-step controller for the CPU clock domain.
// Drives clock_divider.enable, tracks CPU-period boundaries with a local phase
// counter and only halts or changes ratio on those boundaries.
module cpuclk_ctrl #(
   parameter int DIV_W       = 8,
   parameter int STEP_W      = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              run_req,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_n,
   input  logic              div_wr,
   input  logic [DIV_W-1:0]  div_val,
   output logic              enable,
   output logic              cpu_tick,
   output logic [1:0]        state,
   output logic              halted,
   output logic              step_done,
   output logic [DIV_W-1:0]  div_cur,
   output logic [31:0]       tick_count
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_DRAIN = 2'b11
   } state_e;

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_cur_q, div_cur_d;
   logic [DIV_W-1:0]  pend_val_q, pend_val_d;
   logic              pend_q, pend_d;
   logic [STEP_W-1:0] remaining_q, remaining_d;
   logic [31:0]       tick_count_q, tick_count_d;
   logic              step_done_q, step_done_d;
   logic              tick;
   logic              pend_apply;

   // Period boundary and output decode, purely from registered state
   always_comb begin
      tick       = (state_q != ST_HALT) && (cnt_q == (div_cur_q - DIV_W'(1)));
      enable     = (state_q != ST_HALT);
      cpu_tick   = tick;
      state      = state_q;
      halted     = (state_q == ST_HALT);
      step_done  = step_done_q;
      div_cur    = div_cur_q;
      tick_count = tick_count_q;
   end

   // Next-state logic: commands ranked halt > step > run, halts complete the period
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      step_done_d = 1'b0;
      case (state_q)
         ST_HALT: begin
            if (step_req && (step_n != '0)) begin
               state_d     = ST_STEP;
               remaining_d = step_n;
            end else if (run_req) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = tick ? ST_HALT : ST_DRAIN;
            end
         end
         ST_STEP: begin
            if (halt_req) begin
               state_d     = tick ? ST_HALT : ST_DRAIN;
               remaining_d = '0;
            end else if (run_req) begin
               state_d     = ST_RUN;
               remaining_d = '0;
            end else if (tick) begin
               if (remaining_q == STEP_W'(1)) begin
                  state_d     = ST_HALT;
                  remaining_d = '0;
                  step_done_d = 1'b1;
               end else begin
                  remaining_d = remaining_q - STEP_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (run_req) begin
               state_d = ST_RUN;
            end else if (tick) begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d     = ST_HALT;
            remaining_d = '0;
         end
      endcase
   end

   // Phase counter, pending-ratio handoff and period counter
   always_comb begin
      if ((state_q == ST_HALT) || (state_d == ST_HALT) || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      pend_apply = pend_q && ((state_q == ST_HALT) || tick);
      div_cur_d  = pend_apply ? pend_val_q : div_cur_q;

      if (div_wr) begin
         pend_d     = 1'b1;
         pend_val_d = (div_val == '0) ? DIV_W'(1) : div_val;
      end else begin
         pend_d     = pend_apply ? 1'b0 : pend_q;
         pend_val_d = pend_val_q;
      end

      tick_count_d = tick ? (tick_count_q + 32'd1) : tick_count_q;
   end

   // State register bank, cleared asynchronously
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_HALT;
         cnt_q        <= '0;
         div_cur_q    <= DEF_DIV;
         pend_val_q   <= DEF_DIV;
         pend_q       <= 1'b0;
         remaining_q  <= '0;
         tick_count_q <= '0;
         step_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_cur_q    <= div_cur_d;
         pend_val_q   <= pend_val_d;
         pend_q       <= pend_d;
         remaining_q  <= remaining_d;
         tick_count_q <= tick_count_d;
         step_done_q  <= step_done_d;
      end
   end

endmodule

// File: doc/cpuclk_ctrl.md
# cpuclk_ctrl

Run/halt/single-step controller for the CPU clock domain, sitting between the debug/host command interface and `clock_divider`. It drives the divider's `enable`, keeps its own copy of the divide ratio so that CPU-period boundaries are known, and emits a one-cycle `cpu_tick` at the end of every CPU period. Halts and ratio changes take effect only on period boundaries, so the CPU never sees a truncated clock period.

## Interface
- `DIV_W`, default 8: width of divide ratio.
- `STEP_W`, default 16: width of step count.
- `DEFAULT_DIV`, default 2: divide ratio loaded at reset.

- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `run_req` in 1: single-cycle pulse, start/continue free-running.
- `halt_req` in 1: single-cycle pulse, stop at next period boundary.
- `step_req` in 1: single-cycle pulse, run `step_n` CPU periods then halt.
- `step_n` in STEP_W: step count, sampled with `step_req`.
- `div_wr` in 1: single-cycle pulse, new ratio request.
- `div_val` in DIV_W: ratio, sampled with `div_wr`.
- `enable` out 1: to `clock_divider.enable`.
- `cpu_tick` out 1: last system cycle of a CPU period.
- `state` out 2: HALT=00, RUN=01, STEP=10, DRAIN=11.
- `halted` out 1: `state`==HALT.
- `step_done` out 1: one-cycle pulse on step completion.
- `div_cur` out DIV_W: ratio in effect.
- `tick_count` out 32: CPU periods completed, wraps.

## Operation
- Phase counter `cnt` (DIV_W bits) increments while `state`≠HALT. It clears to 0 on the cycle after a tick, and clears on entry to HALT.
- `cpu_tick` = (`state`≠HALT) && (`cnt`==`div_cur`−1). It is decoded from registers only, with no input-to-output path.
- `enable` = (`state`≠HALT). It is decoded from registers.
- `tick_count` increments on every `cpu_tick` and wraps 2^32−1 to 0.
- Ratio:
  - `div_val`=0 is stored as 1.
  - `div_wr` latches into a pending register with a pending flag. The last write wins.
  - Pending ratio is applied in HALT on the next cycle.
  - Pending ratio is applied otherwise on the cycle after a tick, in the same cycle `cnt` returns to 0.
- State transitions, evaluated per cycle:
  - HALT, `run_req` → RUN.
  - HALT, `step_req` with `step_n`≥1 → STEP, `remaining`=`step_n`. `step_n`=0 is ignored.
  - RUN, `halt_req` while `cpu_tick` → HALT.
  - RUN, `halt_req` otherwise → DRAIN.
  - STEP, each tick decrements `remaining`. Tick with `remaining`==1 → HALT and `step_done`=1 the next cycle.
  - STEP, `halt_req` → DRAIN, or → HALT if coincident with a tick. This aborts the step; `step_done` is not pulsed.
  - STEP, `run_req` → RUN. Remaining steps are discarded.
  - DRAIN, next tick → HALT.
  - DRAIN, `run_req` → RUN. The halt is cancelled and `cnt` is not disturbed.
- Simultaneous commands: priority is `halt_req` > `step_req` > `run_req`. Commands not listed for the current state are ignored (e.g. `step_req` in RUN).
- `div_wr` is independent of commands and may coincide with any of them.

## Timing
- Reset values:
  - `state`=HALT, `enable`=0, `cpu_tick`=0, `halted`=1, `step_done`=0.
  - `div_cur`=DEFAULT_DIV, `cnt`=0, `tick_count`=0, pending flag=0, `remaining`=0.
- Reset is asynchronous and may occur mid-period or mid-step. All state returns to reset values immediately, and no `step_done` is emitted.
- Command sampled at edge k → new `state`/`enable` visible from cycle k+1.
- From RUN entry at cycle k+1, with ratio D, ticks occur at cycles k+D, k+2D, …
- DRAIN always completes the current period, so `enable` drops the cycle after a tick, never mid-period.
- A ratio change applied after the tick at cycle t → next tick at t+D_new.
- `step_done` is high for exactly one cycle, coincident with the first HALT cycle.

## Test plan
- Reset, then `run_req` with D=4 → `enable`=1 next cycle. `cpu_tick` every 4 cycles. `tick_count`=25 after 100 RUN cycles.
- RUN at D=4, `halt_req` when `cnt`=1 → DRAIN for 2 cycles, tick, then HALT. `enable`=0 exactly one cycle after the tick.
- HALT, `step_req` with `step_n`=3, D=2 → 3 ticks 2 cycles apart. `step_done` one cycle after the 3rd tick. `halted`=1 and `tick_count`+=3.
- RUN at D=4, `div_wr` 6 at `cnt`=1, then `div_wr` 0 at `cnt`=2 → current period ends at D=4. `div_cur`=1 afterwards and a tick occurs every cycle.
- Same-cycle `halt_req`+`run_req` in RUN → DRAIN. Same-cycle `step_req`+`run_req` in HALT → STEP. `step_req` with `step_n`=0 → stays HALT.
- `nRST` asserted mid-STEP with `remaining`=5 → outputs return to reset values asynchronously, with no `step_done` and `div_cur`=DEFAULT_DIV.
